uart_pim_soc: RTL and testbench
===============================

Name: uart_pim_soc

Overview:
- UART-controlled processing-in-memory SoC.
- A host sends 32-bit command words and row data over a serial line. These load and read a banked row memory (rank/bank-group/row) and trigger a vector compute (nibble dot product) whose result is written back into the memory.
- Read-back data is returned on tx. This is the top level of the chip.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per UART bit (10 MHz clk, about 1 Mbaud).
- RANKS, 16, ranks implemented.
- BGS, 4, bank groups per rank.
- ROWS, 16, 32-bit rows per bank group.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active-high (reset when 1).
- rx  input  1  UART receive, idle high.
- tx  output  1  UART transmit, idle high.

Behaviour:
- Reset: tx=1, all FSMs idle, byte/word counters 0, stream/compute flags cleared, tx FIFO empty. Memory contents are not reset.
- UART frame (both directions): start 0, 8 data bits LSB first, odd parity (data^parity has odd weight), stop 1.
- rx is double-flop synchronised. A falling edge starts a frame. Start is re-checked at CLKS_PER_BIT/2, and each later bit is sampled every CLKS_PER_BIT.
- A frame with bad parity, or stop=0, is discarded and resets the byte-of-word counter.
- Word assembly: 4 bytes, first byte = bits[7:0], last byte = bits[31:24].
- Command fields:
  - [31:29] opcode.
  - [28] direction.
  - [27:20] mem index; only 0 is valid, other values make the command a no-op.
  - [19:15] rank.
  - [14:12] bank group.
  - [11:8] row.
  - [7:0] length in rows.
- Opcode 011, dir 0 (write):
  - The next 4*length received bytes are data, not commands.
  - Each 4-byte group forms one row word, written to consecutive rows starting at the given row.
  - Row index wraps modulo ROWS.
  - Out-of-range rank or bank group: data is consumed but not written.
- Opcode 011, dir 1 (read):
  - Pushes length rows (4 bytes each, LSB byte first) into a 16-byte tx FIFO.
  - Stalls while the FIFO is full; further commands are queued behind the stall, so rx bytes are still captured.
  - Out-of-range address returns 0.
- Opcode 100: bit0=0 opens the instruction stream, bit0=1 closes it. Opcodes 101, 010, 001 and 111 are ignored unless the stream is open. Opcode 011 is always accepted.
- Opcode 101: bit0=0 opens a compute-config block and clears the operand registers. bit0=1 closes the block and executes.
- Opcode 010: [2:0] selects the operation. 0 = DOT; 1 = element-wise ADD mod 16; others = no-op.
- Opcode 001: loads an operand address from [19:8]. [28:27] selects the slot: 10 = source A, 11 = source B, 00 = destination; 01 is ignored.
- Execute:
  - Read A and B, treat each as 8 unsigned nibbles (nibble0 = bits[3:0]).
  - DOT: 32-bit zero-extended sum of the 8 products.
  - ADD: packed nibble sums.
  - Write the result to the destination row.
  - Finish within 16 cycles of the close command.
- Opcode 111: clears the compute-config state. Opcode 110, and 000 unassigned, are ignored.
- Arrival of a new command word while a read is still draining is handled in order.
- Reset mid-frame aborts both rx and tx; tx returns to 1 on the next cycle.

Decomposition:
- Package pim_pkg: opcode constants (OP_DATA=3'b011, OP_STREAM=3'b100, OP_CFG=3'b101, OP_SEL=3'b010, OP_ADDR=3'b001, OP_END=3'b111), field bit positions, op-select codes, slot codes.
- One sub-module, uart_rx_byte: sync + sampling + parity check, outputs byte and valid. TX serializer, FIFO, decoder and memory stay in the top.

Test Plan:
- Write rank2 BG1 row3 with word 0x60011301, then bytes D2 A5 C3 96; read it back with 0x70011301 -> tx sends D2 A5 C3 96 with correct odd parity.
- Write rank6 BG1 row12 (0x60031C01) with 2D 5A 3C 69; open stream (0x80000000) and config (0xA0000000); send op DOT (0x40000000), A=0x30011300, B=0x38031C00, dest=0x2004A800; close config (0xA0000001); read rank9 BG2 row8 (0x7004A801) -> tx sends 4C 01 00 00 (332).
- Same operands with op ADD (0x40000001) -> destination reads FF FF FF FF.
- Config commands sent before the stream is opened -> destination row unchanged.
- Byte with wrong parity inside a command -> word discarded; the next valid 4 bytes are decoded correctly.
- Read command with length 5 -> 20 bytes transmitted without loss (FIFO back-pressure); reset asserted mid-transmission -> tx high and idle.

Source files
------------

// File: rtl/pim_pkg.sv
// rtl/pim_pkg.sv - shared opcodes, command field positions and nibble compute helpers
package pim_pkg;

  localparam logic [2:0] OP_DATA   = 3'b011;
  localparam logic [2:0] OP_STREAM = 3'b100;
  localparam logic [2:0] OP_CFG    = 3'b101;
  localparam logic [2:0] OP_SEL    = 3'b010;
  localparam logic [2:0] OP_ADDR   = 3'b001;
  localparam logic [2:0] OP_END    = 3'b111;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 29;
  localparam int DIR_BIT = 28;
  localparam int SLOT_HI = 28;
  localparam int SLOT_LO = 27;
  localparam int MIDX_HI = 27;
  localparam int MIDX_LO = 20;
  localparam int ADDR_HI = 19;
  localparam int ADDR_LO = 8;
  localparam int LEN_HI  = 7;
  localparam int LEN_LO  = 0;

  localparam logic [2:0] SEL_DOT = 3'd0;
  localparam logic [2:0] SEL_ADD = 3'd1;
  localparam logic [2:0] SEL_NOP = 3'd7;

  localparam logic [1:0] SLOT_A = 2'b10;
  localparam logic [1:0] SLOT_B = 2'b11;
  localparam logic [1:0] SLOT_D = 2'b00;

  typedef struct packed {
    logic [4:0] rank;
    logic [2:0] bg;
    logic [3:0] row;
  } row_addr_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_t;

  function automatic logic [31:0] nib_dot(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + 32'(a[4*i +: 4]) * 32'(b[4*i +: 4]);
    end
    return s;
  endfunction

  function automatic logic [31:0] nib_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = a[4*i +: 4] + b[4*i +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - rx synchroniser and odd-parity UART byte receiver
// Flags err_o for a bad parity or a low stop bit instead of delivering the byte.
module uart_rx_byte
  import pim_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       err_o
);

  localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  rx_state_t   state_q;
  logic        meta_q;
  logic        sync_q;
  logic        prev_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        par_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_o  <= '0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      meta_q  <= rx_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (prev_q && !sync_q) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            shift_q <= {sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_PAR;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RX_PAR: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            par_q   <= sync_q;
            state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (sync_q && (^{shift_q, par_q})) begin
              data_o  <= shift_q;
              valid_o <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_pim_soc.sv
// rtl/uart_pim_soc.sv - UART-controlled processing-in-memory SoC top
// Word queue, command decoder, banked row memory, nibble compute, tx FIFO and serializer.
module uart_pim_soc
  import pim_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int RANKS        = 16,
  parameter int BGS          = 4,
  parameter int ROWS         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic tx
);

  localparam int DEPTH = RANKS * BGS * ROWS;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  function automatic logic [AW-1:0] row_idx(input row_addr_t a);
    return AW'((int'(a.rank) * BGS + int'(a.bg)) * ROWS + int'(a.row));
  endfunction

  function automatic logic row_ok(input row_addr_t a);
    return (int'(a.rank) < RANKS) && (int'(a.bg) < BGS) && (int'(a.row) < ROWS);
  endfunction

  function automatic logic [3:0] row_next(input logic [3:0] r);
    return (int'(r) >= ROWS - 1) ? 4'd0 : r + 4'd1;
  endfunction

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .rx_i   (rx),
    .data_o (rx_data),
    .valid_o(rx_valid),
    .err_o  (rx_err)
  );

  logic [1:0]  bcnt_q;
  logic [23:0] part_q;
  logic [31:0] word;
  logic        word_valid;

  assign word       = {rx_data, part_q};
  assign word_valid = rx_valid && (bcnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst_n || rx_err) begin
      bcnt_q <= '0;
      part_q <= '0;
    end else if (rx_valid) begin
      bcnt_q <= bcnt_q + 2'd1;
      part_q <= {rx_data, part_q[23:8]};
    end
  end

  // Words wait here while a read drains, so rx keeps flowing during tx back-pressure.
  logic [31:0] wq_q [4];
  logic [1:0]  wq_wr_q;
  logic [1:0]  wq_rd_q;
  logic [2:0]  wq_cnt_q;
  logic        wq_push;
  logic        wq_pop;
  logic [31:0] cmd;
  row_addr_t   cmd_addr;

  logic [7:0]  data_rem_q;
  row_addr_t   dw_addr_q;
  logic [7:0]  rd_rem_q;
  row_addr_t   rd_addr_q;
  logic [1:0]  rd_b_q;
  logic        stream_q;
  logic        cfg_q;
  logic        exec_q;
  logic [2:0]  op_q;
  row_addr_t   a_q;
  row_addr_t   b_q;
  row_addr_t   d_q;

  assign cmd      = wq_q[wq_rd_q];
  assign cmd_addr = cmd[ADDR_HI:ADDR_LO];
  assign wq_push  = word_valid && (wq_cnt_q != 3'd4);
  assign wq_pop   = (wq_cnt_q != 3'd0) && (rd_rem_q == 8'd0) && !exec_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wq_wr_q  <= '0;
      wq_rd_q  <= '0;
      wq_cnt_q <= '0;
    end else begin
      if (wq_push) begin
        wq_q[wq_wr_q] <= word;
        wq_wr_q       <= wq_wr_q + 2'd1;
      end
      if (wq_pop) wq_rd_q <= wq_rd_q + 2'd1;
      wq_cnt_q <= wq_cnt_q + {2'b00, wq_push} - {2'b00, wq_pop};
    end
  end

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_word;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] exec_res;
  logic        mem_we_d;
  logic [AW-1:0] mem_waddr_d;
  logic [31:0] mem_wdata_d;

  assign rd_word  = row_ok(rd_addr_q) ? mem_q[row_idx(rd_addr_q)] : '0;
  assign opa      = row_ok(a_q) ? mem_q[row_idx(a_q)] : '0;
  assign opb      = row_ok(b_q) ? mem_q[row_idx(b_q)] : '0;
  assign exec_res = (op_q == SEL_DOT) ? nib_dot(opa, opb) : nib_add(opa, opb);

  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = '0;
    mem_wdata_d = '0;
    if (exec_q && row_ok(d_q) && (op_q == SEL_DOT || op_q == SEL_ADD)) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = row_idx(d_q);
      mem_wdata_d = exec_res;
    end else if (wq_pop && (data_rem_q != 8'd0) && row_ok(dw_addr_q)) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = row_idx(dw_addr_q);
      mem_wdata_d = cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) mem_q[mem_waddr_d] <= mem_wdata_d;
  end

  logic [7:0] fifo_q [16];
  logic [3:0] f_wr_q;
  logic [3:0] f_rd_q;
  logic [4:0] f_cnt_q;
  logic       f_push;
  logic       f_pop;
  logic [7:0] f_din;
  logic [7:0] f_dout;
  logic       tx_busy_q;

  assign f_push = (rd_rem_q != 8'd0) && (f_cnt_q != 5'd16);
  assign f_pop  = !tx_busy_q && (f_cnt_q != 5'd0);
  assign f_din  = rd_word[{rd_b_q, 3'b000} +: 8];
  assign f_dout = fifo_q[f_rd_q];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      data_rem_q <= '0;
      dw_addr_q  <= '0;
      rd_rem_q   <= '0;
      rd_addr_q  <= '0;
      rd_b_q     <= '0;
      stream_q   <= 1'b0;
      cfg_q      <= 1'b0;
      exec_q     <= 1'b0;
      op_q       <= SEL_NOP;
      a_q        <= '0;
      b_q        <= '0;
      d_q        <= '0;
    end else begin
      exec_q <= 1'b0;
      if (f_push) begin
        rd_b_q <= rd_b_q + 2'd1;
        if (rd_b_q == 2'd3) begin
          rd_rem_q      <= rd_rem_q - 8'd1;
          rd_addr_q.row <= row_next(rd_addr_q.row);
        end
      end
      if (wq_pop) begin
        if (data_rem_q != 8'd0) begin
          data_rem_q    <= data_rem_q - 8'd1;
          dw_addr_q.row <= row_next(dw_addr_q.row);
        end else begin
          case (cmd[OPC_HI:OPC_LO])
            OP_DATA: begin
              if (cmd[MIDX_HI:MIDX_LO] == 8'd0) begin
                if (cmd[DIR_BIT]) begin
                  rd_rem_q  <= cmd[LEN_HI:LEN_LO];
                  rd_addr_q <= cmd_addr;
                  rd_b_q    <= '0;
                end else begin
                  data_rem_q <= cmd[LEN_HI:LEN_LO];
                  dw_addr_q  <= cmd_addr;
                end
              end
            end
            OP_STREAM: stream_q <= ~cmd[0];
            OP_CFG: begin
              if (stream_q) begin
                if (!cmd[0]) begin
                  cfg_q <= 1'b1;
                  a_q   <= '0;
                  b_q   <= '0;
                  d_q   <= '0;
                end else if (cfg_q) begin
                  cfg_q  <= 1'b0;
                  exec_q <= 1'b1;
                end
              end
            end
            OP_SEL: if (stream_q) op_q <= cmd[2:0];
            OP_ADDR: begin
              if (stream_q) begin
                case (cmd[SLOT_HI:SLOT_LO])
                  SLOT_A:  a_q <= cmd_addr;
                  SLOT_B:  b_q <= cmd_addr;
                  SLOT_D:  d_q <= cmd_addr;
                  default: ;
                endcase
              end
            end
            OP_END: begin
              if (stream_q) begin
                cfg_q <= 1'b0;
                op_q  <= SEL_NOP;
                a_q   <= '0;
                b_q   <= '0;
                d_q   <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      f_wr_q  <= '0;
      f_rd_q  <= '0;
      f_cnt_q <= '0;
    end else begin
      if (f_push) begin
        fifo_q[f_wr_q] <= f_din;
        f_wr_q         <= f_wr_q + 4'd1;
      end
      if (f_pop) f_rd_q <= f_rd_q + 4'd1;
      f_cnt_q <= f_cnt_q + {4'b0000, f_push} - {4'b0000, f_pop};
    end
  end

  logic        tx_q;
  logic [9:0]  tx_sh_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;

  assign tx = tx_q;

  // tx_sh_q holds data, parity and stop; the start bit is driven at load time.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_sh_q   <= '0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
    end else if (!tx_busy_q) begin
      if (f_pop) begin
        tx_busy_q <= 1'b1;
        tx_q      <= 1'b0;
        tx_sh_q   <= {1'b1, ~^f_dout, f_dout};
        tx_cnt_q  <= '0;
        tx_bit_q  <= '0;
      end
    end else if (tx_cnt_q != BIT_LAST) begin
      tx_cnt_q <= tx_cnt_q + 16'd1;
    end else begin
      tx_cnt_q <= '0;
      if (tx_bit_q == 4'd10) begin
        tx_busy_q <= 1'b0;
        tx_q      <= 1'b1;
      end else begin
        tx_q     <= tx_sh_q[0];
        tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
        tx_bit_q <= tx_bit_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_pim_soc.sv
// tb/tb_uart_pim_soc.sv - directed vector bench for uart_pim_soc
module tb_uart_pim_soc;

  typedef struct {
    logic [31:0] wr;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic tx;

  int n_vec = 0;
  int n_bad = 0;
  int par_err = 0;
  bit mon_en = 1'b1;
  logic [7:0] rxq[$];

  uart_pim_soc #(
    .CLKS_PER_BIT(10),
    .RANKS       (16),
    .BGS         (4),
    .ROWS        (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : tx_monitor
    logic [7:0] b;
    logic p;
    logic s;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (5) @(negedge clk);
        if (tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = tx;
          end
          repeat (10) @(negedge clk);
          p = tx;
          repeat (10) @(negedge clk);
          s = tx;
          if (mon_en) begin
            if (!(^{b, p}) || s !== 1'b1) par_err++;
            rxq.push_back(b);
          end
        end
      end
    end
  end

  // mode 0: good frame, 1: flipped parity, 2: stop bit low
  task automatic send_byte(input logic [7:0] b, input int mode);
    logic [10:0] f;
    f = {(mode != 2), (~^b) ^ (mode == 1), b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rx = f[i];
      repeat (9) @(negedge clk);
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 0);
  endtask

  task automatic get_word(output logic [31:0] w);
    int t;
    t = 0;
    while (rxq.size() < 4 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (rxq.size() < 4) begin
      w = 32'hxxxxxxxx;
    end else begin
      for (int i = 0; i < 4; i++) w[8*i +: 8] = rxq.pop_front();
    end
  endtask

  task automatic read_check(input string name, input logic [31:0] rd, input logic [31:0] exp);
    logic [31:0] w;
    send_word(rd);
    get_word(w);
    check(name, w, exp);
  endtask

  initial begin : main
    vec_t vt[9];
    logic [31:0] cfg_dot[6] = '{32'hA0000000, 32'h40000000, 32'h30011300,
                                32'h38031C00, 32'h2004A800, 32'hA0000001};
    logic [31:0] cfg_add[6] = '{32'hA0000000, 32'h40000001, 32'h30011300,
                                32'h38031C00, 32'h2004A800, 32'hA0000001};
    logic [31:0] lw[5] = '{32'hA0B0C0D0, 32'h11223344, 32'h55667788,
                           32'h99AABBCC, 32'hDDEEFF00};
    logic [31:0] w;
    int lows;
    int t;

    vt[0] = '{32'h60011301, 32'h96C3A5D2, 32'h0, 32'h70011301, 32'h96C3A5D2};
    vt[1] = '{32'h60031C01, 32'h693C5A2D, 32'h0, 32'h70031C01, 32'h693C5A2D};
    vt[2] = '{32'h60000F02, 32'h11111111, 32'h22222222, 32'h70000001, 32'h22222222};
    vt[3] = '{32'h0, 32'h0, 32'h0, 32'h70000F01, 32'h11111111};
    vt[4] = '{32'h60080001, 32'h12345678, 32'h0, 32'h70080001, 32'h0};
    vt[5] = '{32'h60004001, 32'h87654321, 32'h0, 32'h70004001, 32'h0};
    vt[6] = '{32'h0, 32'h0, 32'h0, 32'h70000001, 32'h22222222};
    vt[7] = '{32'h60111301, 32'hDEADBEEF, 32'h0, 32'h70011301, 32'h96C3A5D2};
    vt[8] = '{32'h6007B001, 32'hCAFEF00D, 32'h0, 32'h7007B001, 32'hCAFEF00D};

    rst_n = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    rst_n = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_tx", {31'd0, tx}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      if (vt[i].wr != 32'h0) begin
        send_word(vt[i].wr);
        send_word(vt[i].d0);
        if (vt[i].wr[7:0] == 8'd2) send_word(vt[i].d1);
      end
      read_check($sformatf("vec%0d", i), vt[i].rd, vt[i].exp);
    end

    send_word(32'h80000000);
    for (int i = 0; i < 6; i++) send_word(cfg_dot[i]);
    read_check("dot", 32'h7004A801, 32'h0000014C);

    for (int i = 0; i < 6; i++) send_word(cfg_add[i]);
    read_check("add", 32'h7004A801, 32'hFFFFFFFF);

    send_word(32'h80000001);
    for (int i = 0; i < 6; i++) send_word(cfg_dot[i]);
    read_check("no_stream", 32'h7004A801, 32'hFFFFFFFF);

    send_byte(8'h01, 0);
    send_byte(8'h13, 1);
    read_check("parity_drop", 32'h7004A801, 32'hFFFFFFFF);
    repeat (400) @(negedge clk);
    check("parity_extra", rxq.size(), 32'd0);

    send_byte(8'h01, 0);
    send_byte(8'hA8, 2);
    read_check("stop_drop", 32'h7004A801, 32'hFFFFFFFF);

    send_word(32'h60011305);
    for (int i = 0; i < 5; i++) send_word(lw[i]);
    send_word(32'h70011305);
    send_word(32'h70011301);
    for (int i = 0; i < 6; i++) begin
      get_word(w);
      check($sformatf("burst%0d", i), w, (i < 5) ? lw[i] : lw[0]);
    end

    send_word(32'h70011305);
    repeat (250) @(negedge clk);
    t = 0;
    while (tx !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("tx_start_seen", {31'd0, tx}, 32'd0);
    mon_en = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    check("rst_tx_high", {31'd0, tx}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    lows  = 0;
    repeat (1500) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("rst_tx_idle", lows, 32'd0);
    rxq.delete();
    mon_en = 1'b1;

    read_check("after_reset", 32'h70011301, lw[0]);
    check("tx_parity", par_err, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
